// File: rtl/hazard_pkg.sv
// Shared forwarding encodings and the register address match rule
// used by the hazard unit and its multiplier scoreboard.
package hazard_pkg;

   localparam logic [1:0] FW_RF  = 2'd0;
   localparam logic [1:0] FW_MEM = 2'd1;
   localparam logic [1:0] FW_WB  = 2'd2;
   localparam logic [1:0] FW_MUL = 2'd3;

   // Callers zero-extend addresses to 16 bits; the hard-wired zero register never matches.
   function automatic logic addr_match(
      input logic [15:0] a,
      input logic [15:0] b,
      input logic        zero_reg
   );
      return (a == b) && !(zero_reg && (a == 16'd0));
   endfunction

endpackage

// File: rtl/mul_scoreboard.sv
// One-entry scoreboard for the non-pipelined multiplier: tracks the
// outstanding destination and pulses mul_wb on the writeback cycle.
module mul_scoreboard
   import hazard_pkg::*;
#(
   parameter int AW      = 5,
   parameter int MUL_LAT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mul_e,
   input  logic          taken_e,
   input  logic [AW-1:0] wa_e,
   output logic          mul_wb,
   output logic [AW-1:0] mul_wa,
   output logic          mul_busy
);

   logic [3:0] cnt;
   logic       issue;

   assign issue  = mul_e && !taken_e;
   assign mul_wb = mul_busy && (cnt == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_busy <= 1'b0;
         cnt      <= 4'd0;
         mul_wa   <= '0;
      end else if (issue) begin
         mul_busy <= 1'b1;
         cnt      <= 4'(MUL_LAT - 1);
         mul_wa   <= wa_e;
      end else if (mul_busy) begin
         if (cnt == 4'd0) begin
            mul_busy <= 1'b0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // The D-stage structural stall must keep a second multiply out of E.
   a_no_issue_busy : assert property (
      @(posedge clk) disable iff (rst) !(mul_e && mul_busy)
   );

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard/forwarding unit with N read ports, taken-branch
// flush and a scoreboard for the multi-cycle multiplier.
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int MUL_LAT  = 3,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NRD*AW-1:0] RA_D,
   input  logic [NRD*AW-1:0] RA_E,
   input  logic [AW-1:0]     WA_D,
   input  logic [AW-1:0]     WA_E,
   input  logic [AW-1:0]     WA_M,
   input  logic [AW-1:0]     WA_W,
   input  logic              Load_E,
   input  logic              Mul_D,
   input  logic              Mul_E,
   input  logic              WEN_M,
   input  logic              WEN_W,
   input  logic              Taken_E,
   output logic              PCWrite,
   output logic              FDWrite,
   output logic              FDFlush,
   output logic              DEFlush,
   output logic [NRD*2-1:0]  FW,
   output logic              MulWB,
   output logic [AW-1:0]     MulWA,
   output logic              MulBusy
);

   localparam logic ZR = (ZERO_REG != 0);

   logic [NRD-1:0] ld_hit;
   logic [NRD-1:0] raw_hit;
   logic           waw_hit;
   logic           load_use;
   logic           mul_haz;
   logic           stall;

   mul_scoreboard #(
      .AW      (AW),
      .MUL_LAT (MUL_LAT)
   ) u_sb (
      .clk      (CLK),
      .rst      (RST),
      .mul_e    (Mul_E),
      .taken_e  (Taken_E),
      .wa_e     (WA_E),
      .mul_wb   (MulWB),
      .mul_wa   (MulWA),
      .mul_busy (MulBusy)
   );

   generate
      for (genvar i = 0; i < NRD; i++) begin : g_port
         logic [AW-1:0] ra_d;
         logic [AW-1:0] ra_e;
         logic [1:0]    fw;

         assign ra_d       = RA_D[i*AW +: AW];
         assign ra_e       = RA_E[i*AW +: AW];
         assign ld_hit[i]  = addr_match(16'(ra_d), 16'(WA_E), ZR);
         assign raw_hit[i] = addr_match(16'(ra_d), 16'(MulWA), ZR);

         always_comb begin
            fw = FW_RF;
            if (RST) begin
               fw = FW_RF;
            end else if (MulWB && addr_match(16'(ra_e), 16'(MulWA), ZR)) begin
               fw = FW_MUL;
            end else if (!WEN_M && addr_match(16'(ra_e), 16'(WA_M), ZR)) begin
               fw = FW_MEM;
            end else if (!WEN_W && addr_match(16'(ra_e), 16'(WA_W), ZR)) begin
               fw = FW_WB;
            end
         end

         assign FW[i*2 +: 2] = fw;
      end
   endgenerate

   assign waw_hit  = addr_match(16'(WA_D), 16'(MulWA), ZR);
   assign load_use = Load_E && (|ld_hit);
   // The result lands in the MulWB cycle, so data hazards clear then; the unit itself does not.
   assign mul_haz  = MulBusy && (Mul_D || (!MulWB && ((|raw_hit) || waw_hit)));
   assign stall    = load_use || mul_haz;

   always_comb begin
      PCWrite = 1'b1;
      FDWrite = 1'b1;
      FDFlush = 1'b0;
      DEFlush = 1'b0;
      if (!RST) begin
         if (Taken_E) begin
            FDFlush = 1'b1;
            DEFlush = 1'b1;
         end else if (stall) begin
            PCWrite = 1'b0;
            FDWrite = 1'b0;
            DEFlush = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed testbench for hazard_unit_sb (NRD=2 and NRD=3 builds).
module tb_hazard_unit_sb;
   import hazard_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [9:0]  RA_D, RA_E;
   logic [14:0] RA_D3, RA_E3;
   logic [4:0]  WA_D, WA_E, WA_M, WA_W;
   logic        Load_E, Mul_D, Mul_E, WEN_M, WEN_W, Taken_E;
   logic        PCWrite, FDWrite, FDFlush, DEFlush, MulWB, MulBusy;
   logic [3:0]  FW;
   logic [4:0]  MulWA;
   logic        PCWrite3, FDWrite3, FDFlush3, DEFlush3, MulWB3, MulBusy3;
   logic [5:0]  FW3;
   logic [4:0]  MulWA3;
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   hazard_unit_sb dut (
      .CLK(CLK), .RST(RST), .RA_D(RA_D), .RA_E(RA_E),
      .WA_D(WA_D), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
      .Load_E(Load_E), .Mul_D(Mul_D), .Mul_E(Mul_E),
      .WEN_M(WEN_M), .WEN_W(WEN_W), .Taken_E(Taken_E),
      .PCWrite(PCWrite), .FDWrite(FDWrite), .FDFlush(FDFlush),
      .DEFlush(DEFlush), .FW(FW), .MulWB(MulWB), .MulWA(MulWA),
      .MulBusy(MulBusy)
   );

   hazard_unit_sb #(.NRD(3)) dut3 (
      .CLK(CLK), .RST(RST), .RA_D(RA_D3), .RA_E(RA_E3),
      .WA_D(WA_D), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
      .Load_E(Load_E), .Mul_D(Mul_D), .Mul_E(Mul_E),
      .WEN_M(WEN_M), .WEN_W(WEN_W), .Taken_E(Taken_E),
      .PCWrite(PCWrite3), .FDWrite(FDWrite3), .FDFlush(FDFlush3),
      .DEFlush(DEFlush3), .FW(FW3), .MulWB(MulWB3), .MulWA(MulWA3),
      .MulBusy(MulBusy3)
   );

   task automatic idle();
      RA_D = '0; RA_E = '0; RA_D3 = '0; RA_E3 = '0;
      WA_D = '0; WA_E = '0; WA_M = '0; WA_W = '0;
      Load_E = 0; Mul_D = 0; Mul_E = 0;
      WEN_M = 1; WEN_W = 1; Taken_E = 0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      idle();
      RST = 1;
      Load_E = 1; WA_E = 5'd3; RA_D = {5'd0, 5'd3};
      WEN_M = 0; WA_M = 5'd5; RA_E = {5'd0, 5'd5};
      step();
      checks++;
      if (PCWrite !== 1'b1 || FDWrite !== 1'b1) begin
         errors++;
         $display("FAIL rst_enables got %b%b exp 11", PCWrite, FDWrite);
      end
      checks++;
      if (FDFlush !== 1'b0 || DEFlush !== 1'b0) begin
         errors++;
         $display("FAIL rst_flush got %b%b exp 00", FDFlush, DEFlush);
      end
      checks++;
      if (FW !== 4'd0) begin
         errors++;
         $display("FAIL rst_fw got %h exp 0", FW);
      end
      checks++;
      if (MulBusy !== 1'b0 || MulWB !== 1'b0 || MulWA !== 5'd0) begin
         errors++;
         $display("FAIL rst_sb got busy=%b wb=%b wa=%0d exp 0 0 0",
                  MulBusy, MulWB, MulWA);
      end
      idle();
      RST = 0;
      step();
   endtask

   task automatic test_load_use();
      idle();
      Load_E = 1; WA_E = 5'd3; RA_D = {5'd3, 5'd1};
      #1;
      checks++;
      if ({PCWrite, FDWrite, DEFlush, FDFlush} !== 4'b0010) begin
         errors++;
         $display("FAIL load_use got %b exp 0010",
                  {PCWrite, FDWrite, DEFlush, FDFlush});
      end
      step();
      Load_E = 0;
      #1;
      checks++;
      if ({PCWrite, FDWrite, DEFlush} !== 3'b110) begin
         errors++;
         $display("FAIL load_use_release got %b exp 110",
                  {PCWrite, FDWrite, DEFlush});
      end
      Load_E = 1; WA_E = 5'd0; RA_D = {5'd0, 5'd1};
      #1;
      checks++;
      if ({PCWrite, FDWrite, DEFlush} !== 3'b110) begin
         errors++;
         $display("FAIL load_use_r0 got %b exp 110",
                  {PCWrite, FDWrite, DEFlush});
      end
      idle();
      step();
   endtask

   task automatic test_forward();
      idle();
      WEN_M = 0; WA_M = 5'd5; WEN_W = 0; WA_W = 5'd5;
      RA_E = {5'd2, 5'd5};
      RA_E3 = {5'd5, 5'd0, 5'd0};
      #1;
      checks++;
      if (FW !== {FW_RF, FW_MEM}) begin
         errors++;
         $display("FAIL fw_mem got %h exp 1", FW);
      end
      checks++;
      if (FW3 !== {FW_MEM, FW_RF, FW_RF}) begin
         errors++;
         $display("FAIL fw3_mem got %h exp 10", FW3);
      end
      WEN_M = 1;
      #1;
      checks++;
      if (FW !== {FW_RF, FW_WB}) begin
         errors++;
         $display("FAIL fw_wb got %h exp 2", FW);
      end
      checks++;
      if (FW3 !== {FW_WB, FW_RF, FW_RF}) begin
         errors++;
         $display("FAIL fw3_wb got %h exp 20", FW3);
      end
      WEN_W = 1; WEN_M = 0; WA_M = 5'd2;
      #1;
      checks++;
      if (FW !== {FW_MEM, FW_RF}) begin
         errors++;
         $display("FAIL fw_port1 got %h exp 4", FW);
      end
      WA_M = 5'd0; RA_E = '0;
      #1;
      checks++;
      if (FW !== 4'd0) begin
         errors++;
         $display("FAIL fw_r0 got %h exp 0", FW);
      end
      idle();
      step();
   endtask

   task automatic test_mul();
      idle();
      Mul_E = 1; WA_E = 5'd7;
      step();
      Mul_E = 0; WA_E = 5'd0; RA_D = {5'd0, 5'd7};
      #1;
      checks++;
      if ({MulBusy, MulWB, MulWA} !== {2'b10, 5'd7}) begin
         errors++;
         $display("FAIL mul_t1 got busy=%b wb=%b wa=%0d exp 1 0 7",
                  MulBusy, MulWB, MulWA);
      end
      checks++;
      if ({PCWrite, FDWrite, DEFlush} !== 3'b001) begin
         errors++;
         $display("FAIL mul_raw got %b exp 001",
                  {PCWrite, FDWrite, DEFlush});
      end
      step();
      RA_D = '0; WA_D = 5'd7;
      #1;
      checks++;
      if ({MulBusy, MulWB} !== 2'b10) begin
         errors++;
         $display("FAIL mul_t2 got %b%b exp 10", MulBusy, MulWB);
      end
      checks++;
      if ({PCWrite, FDWrite, DEFlush} !== 3'b001) begin
         errors++;
         $display("FAIL mul_waw got %b exp 001",
                  {PCWrite, FDWrite, DEFlush});
      end
      step();
      RA_D = {5'd0, 5'd7}; RA_E = {5'd0, 5'd7};
      WEN_M = 0; WA_M = 5'd7;
      #1;
      checks++;
      if ({MulBusy, MulWB} !== 2'b11) begin
         errors++;
         $display("FAIL mul_t3 got %b%b exp 11", MulBusy, MulWB);
      end
      checks++;
      if ({PCWrite, FDWrite, DEFlush} !== 3'b110) begin
         errors++;
         $display("FAIL mul_wb_nostall got %b exp 110",
                  {PCWrite, FDWrite, DEFlush});
      end
      checks++;
      if (FW !== {FW_RF, FW_MUL}) begin
         errors++;
         $display("FAIL mul_fw got %h exp 3", FW);
      end
      step();
      idle();
      RA_D = {5'd0, 5'd7};
      #1;
      checks++;
      if ({MulBusy, MulWB, PCWrite} !== 3'b001) begin
         errors++;
         $display("FAIL mul_t4 got %b exp 001", {MulBusy, MulWB, PCWrite});
      end
      idle();
      step();
   endtask

   task automatic test_struct();
      idle();
      Mul_E = 1; WA_E = 5'd9;
      step();
      idle();
      Mul_D = 1; RA_D = {5'd2, 5'd1};
      for (int c = 1; c <= 3; c++) begin
         #1;
         checks++;
         if ({PCWrite, FDWrite, DEFlush} !== 3'b001) begin
            errors++;
            $display("FAIL struct_stall c%0d got %b exp 001",
                     c, {PCWrite, FDWrite, DEFlush});
         end
         step();
      end
      #1;
      checks++;
      if ({MulBusy, PCWrite, FDWrite, DEFlush} !== 4'b0110) begin
         errors++;
         $display("FAIL struct_release got %b exp 0110",
                  {MulBusy, PCWrite, FDWrite, DEFlush});
      end
      step();
      idle();
      Mul_E = 1; WA_E = 5'd10;
      step();
      idle();
      #1;
      checks++;
      if ({MulBusy, MulWA} !== {1'b1, 5'd10}) begin
         errors++;
         $display("FAIL struct_reissue got busy=%b wa=%0d exp 1 10",
                  MulBusy, MulWA);
      end
      repeat (3) step();
      checks++;
      if (MulBusy !== 1'b0) begin
         errors++;
         $display("FAIL struct_drain got %b exp 0", MulBusy);
      end
   endtask

   task automatic test_taken();
      idle();
      Load_E = 1; WA_E = 5'd3; RA_D = {5'd3, 5'd0};
      Mul_E = 1; Taken_E = 1;
      #1;
      checks++;
      if ({FDFlush, DEFlush, PCWrite, FDWrite} !== 4'b1111) begin
         errors++;
         $display("FAIL taken got %b exp 1111",
                  {FDFlush, DEFlush, PCWrite, FDWrite});
      end
      step();
      idle();
      #1;
      checks++;
      if (MulBusy !== 1'b0) begin
         errors++;
         $display("FAIL taken_cancel got busy=%b exp 0", MulBusy);
      end
      step();
   endtask

   task automatic test_reset_mid();
      idle();
      Mul_E = 1; WA_E = 5'd6;
      step();
      idle();
      step();
      checks++;
      if (MulBusy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre got %b exp 1", MulBusy);
      end
      Load_E = 1; WA_E = 5'd4; RA_D = {5'd0, 5'd4};
      WEN_M = 0; WA_M = 5'd6; RA_E = {5'd6, 5'd6};
      RST = 1;
      #1;
      checks++;
      if ({MulBusy, MulWB, PCWrite, FDWrite, FDFlush, DEFlush} !== 6'b001100) begin
         errors++;
         $display("FAIL rmid_out got %b exp 001100",
                  {MulBusy, MulWB, PCWrite, FDWrite, FDFlush, DEFlush});
      end
      checks++;
      if (FW !== 4'd0 || MulWA !== 5'd0) begin
         errors++;
         $display("FAIL rmid_fw got fw=%h wa=%0d exp 0 0", FW, MulWA);
      end
      step();
      idle();
      RST = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({MulBusy, MulWB} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_nowb c%0d got %b%b exp 00", c, MulBusy, MulWB);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forward();
      test_mul();
      test_struct();
      test_taken();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised successor to the pipeline hazard/forwarding unit of the 5-stage core (F/D/E/M/W).
- Adds N read ports, an optional zero-register exclusion, taken-branch flush, and a one-entry scoreboard for a non-pipelined multi-cycle multiplier.
- Sits beside the pipeline registers and drives PC/FD write enables, FD/DE flushes and per-port forwarding selects.

Parameters:
- AW, 5, register address width.
- NRD, 2, read ports per instruction (NRD >= 1).
- MUL_LAT, 3, multiplier cycles from issue in E to result writeback (2..15).
- ZERO_REG, 1, if 1 then address 0 never hazards or forwards.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- RA_D  in  NRD*AW  decode read addresses; port i at [i*AW +: AW].
- RA_E  in  NRD*AW  execute read addresses.
- WA_D, WA_E, WA_M, WA_W  in  AW  write addresses per stage.
- Load_E  in  1  load in E.
- Mul_D  in  1  multiply in D.
- Mul_E  in  1  multiply in E (issue strobe).
- WEN_M, WEN_W  in  1  register write enable, active-low.
- Taken_E  in  1  branch/jump resolved taken in E.
- PCWrite, FDWrite  out  1  stage enables, 1 = advance.
- FDFlush, DEFlush  out  1  bubble insertion.
- FW  out  NRD*2  per-port forward select (0 regfile, 1 M, 2 W, 3 mul result).
- MulWB  out  1  1-cycle pulse: multiplier result written this cycle.
- MulWA  out  AW  destination of outstanding multiply.
- MulBusy  out  1  scoreboard entry valid.

Behaviour:
- Valid address: with ZERO_REG=1, address 0 never matches anything.
- Load-use: Load_E and any RA_D port equals WA_E -> PCWrite=0, FDWrite=0, DEFlush=1.
- Mul hazard, evaluated while MulBusy:
  - any RA_D port equals MulWA (RAW), WA_D equals MulWA (WAW), or Mul_D (structural) -> same stall as load-use.
  - Exception: in the MulWB cycle the RAW and WAW terms are cleared.
- Taken_E -> FDFlush=1, DEFlush=1, PCWrite=1, FDWrite=1. Taken_E overrides any stall in the same cycle.
- Forwarding per port i, priority order:
  - (a) MulWB and RA_E[i] equals MulWA -> 3;
  - (b) WEN_M=0 and RA_E[i] equals WA_M -> 1;
  - (c) WEN_W=0 and RA_E[i] equals WA_W -> 2;
  - (d) otherwise 0.
- Forwarding is combinational and independent of stall/flush.
- Scoreboard (sequential):
  - Mul_E=1 and not Taken_E: load MulWA<=WA_E, cnt<=MUL_LAT-1, MulBusy<=1.
  - Mul_E is never asserted while MulBusy; the D-stage structural stall guarantees this. Assertion checks it.
  - While MulBusy and cnt!=0: cnt decrements by 1 per cycle.
  - MulWB = MulBusy and cnt==0, combinational. On that cycle MulBusy<=0.
  - Issue to MulWB spacing is exactly MUL_LAT cycles.
- Taken_E does not cancel an already-outstanding multiply; it cancels only a multiply issuing in that same cycle.
- cnt width: 4 bits.
- Reset: asynchronous; MulBusy=0, cnt=0, MulWA=0.
- Outputs during reset: PCWrite=1, FDWrite=1, flushes 0, FW=0, MulWB=0.
- Asserting RST mid-multiply discards the entry with no MulWB pulse.

Decomposition:
- Shared package hazard_pkg: FW_RF=0, FW_MEM=1, FW_WB=2, FW_MUL=3 constants; an addr_match function applying the ZERO_REG rule.
- One sub-module, mul_scoreboard: counter, MulWA, MulBusy and MulWB.
- The top module holds the per-port generate loops for stall and forwarding.

Test Plan:
- Load_E=1, WA_E=3, RA_D port1=3 -> PCWrite=0, FDWrite=0, DEFlush=1 for 1 cycle; same with WA_E=0 and ZERO_REG=1 -> no stall.
- WEN_M=0, WA_M=5 and WEN_W=0, WA_W=5, RA_E port0=5 -> FW[1:0]=1; then WEN_M=1 -> FW[1:0]=2.
- Mul_E=1, WA_E=7 at cycle t, MUL_LAT=3:
  - MulBusy=1 over t+1..t+3.
  - MulWB=1 at t+3 only.
  - RA_D=7 stalls at t+1 and t+2, with no stall at t+3.
  - RA_E=7 at t+3 -> FW=3.
- Mul_D=1 while MulBusy -> stall until the MulWB cycle, then the new issue is accepted the next cycle.
- Taken_E=1 with Mul_E=1 and load-use active -> FDFlush=1, DEFlush=1, PCWrite=1, MulBusy stays 0.
- RST pulsed mid-multiply (cnt=1) -> MulBusy=0 immediately, no MulWB, all outputs at reset values; NRD=3 build repeats the forwarding scenario on port 2.
